hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the statistics counters.
REQ-002 Parameter: WAIT_MAX, 15, maximum number of data-memory wait cycles before the error state is entered.
REQ-003 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_valid  in  1  the IF/ID register holds a real instruction.
REQ-006 id_rs, id_rt  in  5 each  source registers of the instruction in decode.
REQ-007 ex_memread  in  1  the instruction in EX is a load.
REQ-008 ex_rt  in  5  destination register of the load in EX.
REQ-009 mem_branch_taken  in  1  branch taken in MEM (PCSrc).
REQ-010 dmem_req  in  1  the MEM stage instruction accesses data memory.
REQ-011 dmem_ready  in  1  data memory completes the access this cycle.
REQ-012 pc_write  out  1  PC register load enable.
REQ-013 if_id_write  out  1  IF/ID register load enable.
REQ-014 id_ex_bubble  out  1  zero the WB/M/EX control fields entering ID/EX.
REQ-015 if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  clear the valid/control bits of the named register.
REQ-016 pipe_hold  out  1  freeze the ID/EX, EX/MEM and MEM/WB registers.
REQ-017 state  out  2  current FSM state.
REQ-018 err  out  1  memory timeout error flag (sticky).
REQ-019 stall_count, flush_count  out  CNT_W each  statistics counters.

Function
REQ-020 FSM states SHALL be encoded as RUN=00, LU_STALL=01, MEM_WAIT=10, ERROR=11.
REQ-021 Control outputs SHALL be combinational from state and current inputs; state, wait counter, err and statistics counters SHALL be registered.
REQ-022 A load-use hazard exists when id_valid & ex_memread & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
REQ-023 Memory wait exists when dmem_req & !dmem_ready.
REQ-024 Priority in RUN and LU_STALL SHALL be: memory wait > branch taken > load-use.
REQ-025 Memory wait in RUN or LU_STALL SHALL assert pipe_hold=1, pc_write=0 and if_id_write=0, with all flushes and bubble at 0, and the FSM SHALL go to MEM_WAIT with the wait counter set to 1.
REQ-026 In MEM_WAIT, while dmem_ready=0, the block SHALL hold the outputs of REQ-025 and increment the wait counter.
REQ-027 When the wait counter equals WAIT_MAX and dmem_ready=0, the FSM SHALL go to ERROR.
REQ-028 dmem_ready=1 in MEM_WAIT SHALL release the hold in that same cycle, clear the wait counter and return the FSM to RUN.
REQ-029 A branch taken with no memory wait SHALL assert if_id_flush, id_ex_flush and ex_mem_flush with pc_write=1 in the same cycle, and SHALL increment flush_count.
REQ-030 A branch taken SHALL suppress load-use detection in that cycle, and the FSM SHALL go to RUN.
REQ-031 A load-use hazard in RUN SHALL assert pc_write=0, if_id_write=0 and id_ex_bubble=1, and the FSM SHALL go to LU_STALL.
REQ-032 LU_STALL SHALL last exactly one cycle, SHALL suppress load-use detection, and SHALL return to RUN unless REQ-025 applies.
REQ-033 ERROR SHALL be exited only by reset; in ERROR the block SHALL keep pipe_hold=1, pc_write=0, if_id_write=0 and err=1.
REQ-034 stall_count SHALL increment once per bubble cycle and once per cycle with pipe_hold=1.
REQ-035 Both statistics counters SHALL saturate at all-ones and never wrap.
REQ-036 dmem_req and mem_branch_taken asserted together SHALL be treated as a memory wait only; the branch SHALL be evaluated on the cycle the hold releases.
REQ-037 In RUN with no event, outputs SHALL be pc_write=1, if_id_write=1 and all other control outputs 0.

Reset
REQ-038 On rst_n=0, immediately and regardless of state: state=RUN, wait counter=0, err=0, stall_count=0, flush_count=0, pc_write=1, if_id_write=1, all other control outputs 0.
REQ-039 Deassertion of rst_n mid-operation SHALL resume in RUN, with no pending stall or flush carried over.

Verification
REQ-040 lw in EX with ex_rt=5, decode id_rs=5 -> one cycle of pc_write=0 and id_ex_bubble=1, state 01, then 00; stall_count=1.
REQ-041 ex_rt=0 matching id_rt=0 with ex_memread=1 -> no stall, outputs per REQ-037.
REQ-042 mem_branch_taken=1 -> all three flushes and pc_write=1 for one cycle; flush_count=1; a simultaneous load-use hazard is ignored.
REQ-043 dmem_req=1 with dmem_ready low for 3 cycles, then high -> pipe_hold=1 for 3 cycles, released on the ready cycle; stall_count=3; state 00.
REQ-044 dmem_ready held low for 16 cycles with WAIT_MAX=15 -> state 11 and err=1 persist; rst_n pulse -> all values per REQ-038.
REQ-045 Preload stall_count to all-ones via 2^CNT_W stall cycles (CNT_W=4 build) -> count stays at 15.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side uses the master modport; the controller uses the slave modport.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             mem_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             pipe_hold;
  logic [1:0]       state;
  logic             err;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_rs, id_rt, ex_memread, ex_rt, mem_branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush,
           pipe_hold, state, err, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, ex_memread, ex_rt, mem_branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush,
           pipe_hold, state, err, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory wait hold with timeout,
// plus saturating stall/flush statistics.
module hazard_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave io_bus
);

  localparam int unsigned WaitW = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StLuStall = 2'b01,
    StMemWait = 2'b10,
    StError   = 2'b11
  } state_e;

  state_e           r_state, w_state_d;
  logic [WaitW-1:0] r_wait, w_wait_d;
  logic             r_err, w_err_d;
  logic [CNT_W-1:0] r_stall_count, r_flush_count;

  logic w_load_use, w_mem_wait;
  logic w_pc_write, w_if_id_write, w_bubble, w_flush, w_hold;

  assign w_load_use = io_bus.id_valid & io_bus.ex_memread & (io_bus.ex_rt != 5'd0) &
                      ((io_bus.ex_rt == io_bus.id_rs) | (io_bus.ex_rt == io_bus.id_rt));
  assign w_mem_wait = io_bus.dmem_req & ~io_bus.dmem_ready;

  always_comb begin
    w_state_d     = r_state;
    w_wait_d      = r_wait;
    w_err_d       = r_err;
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_bubble      = 1'b0;
    w_flush       = 1'b0;
    w_hold        = 1'b0;

    unique case (r_state)
      StRun, StLuStall: begin
        if (w_mem_wait) begin
          w_hold        = 1'b1;
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_state_d     = StMemWait;
          w_wait_d      = WaitW'(1);
        end else if (io_bus.mem_branch_taken) begin
          w_flush   = 1'b1;
          w_state_d = StRun;
        end else if (w_load_use && (r_state == StRun)) begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_bubble      = 1'b1;
          w_state_d     = StLuStall;
        end else begin
          w_state_d = StRun;
        end
      end
      StMemWait: begin
        if (io_bus.dmem_ready) begin
          // A branch held back behind the memory wait takes effect on the release cycle.
          w_flush   = io_bus.mem_branch_taken;
          w_wait_d  = '0;
          w_state_d = StRun;
        end else begin
          w_hold        = 1'b1;
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          if (r_wait == WaitW'(WAIT_MAX)) begin
            w_state_d = StError;
            w_err_d   = 1'b1;
          end else begin
            w_wait_d = r_wait + WaitW'(1);
          end
        end
      end
      StError: begin
        w_hold        = 1'b1;
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_err_d       = 1'b1;
      end
    endcase

    // Reset forces the idle control pattern even before the clock runs.
    if (!rst_n) begin
      w_pc_write    = 1'b1;
      w_if_id_write = 1'b1;
      w_bubble      = 1'b0;
      w_flush       = 1'b0;
      w_hold        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StRun;
      r_wait        <= '0;
      r_err         <= 1'b0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_wait  <= w_wait_d;
      r_err   <= w_err_d;
      if ((w_hold || w_bubble) && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (w_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign io_bus.pc_write     = w_pc_write;
  assign io_bus.if_id_write  = w_if_id_write;
  assign io_bus.id_ex_bubble = w_bubble;
  assign io_bus.if_id_flush  = w_flush;
  assign io_bus.id_ex_flush  = w_flush;
  assign io_bus.ex_mem_flush = w_flush;
  assign io_bus.pipe_hold    = w_hold;
  assign io_bus.state        = r_state;
  assign io_bus.err          = r_err;
  assign io_bus.stall_count  = r_stall_count;
  assign io_bus.flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then randomized traffic, every cycle
// compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int unsigned CW   = 4;
  localparam int unsigned WM   = 15;
  localparam int          MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic [1:0]    state;
    logic          err;
    logic          pc;
    logic          ifid;
    logic          bub;
    logic          f_ifid;
    logic          f_idex;
    logic          f_exmem;
    logic          hold;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } obs_t;

  typedef struct packed {
    bit       rst_n;
    bit       valid;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       memread;
    bit [4:0] exrt;
    bit       br;
    bit       req;
    bit       ready;
  } stim_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(
    .CNT_W   (CW),
    .WAIT_MAX(WM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  obs_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Model state: what the pipeline controller is currently doing, in plain terms.
  bit m_dead, m_waiting, m_just_stalled, m_err;
  int m_wait, m_stall, m_flush;

  function automatic int sat(int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  function automatic obs_t model(stim_t s);
    obs_t e;
    bit   lu, mw;
    if (!s.rst_n) begin
      m_dead = 0; m_waiting = 0; m_just_stalled = 0; m_err = 0;
      m_wait = 0; m_stall = 0; m_flush = 0;
    end
    e       = '0;
    e.pc    = 1'b1;
    e.ifid  = 1'b1;
    e.state = m_dead ? 2'd3 : m_waiting ? 2'd2 : m_just_stalled ? 2'd1 : 2'd0;
    e.err   = m_err;
    e.stall = CW'(m_stall);
    e.flush = CW'(m_flush);
    if (!s.rst_n) return e;
    lu = s.valid && s.memread && (s.exrt != 0) && ((s.exrt == s.rs) || (s.exrt == s.rt));
    mw = s.req && !s.ready;
    if (m_dead) begin
      e.hold = 1; e.pc = 0; e.ifid = 0;
      m_stall = sat(m_stall);
    end else if (m_waiting) begin
      if (s.ready) begin
        m_waiting = 0; m_wait = 0;
        if (s.br) begin
          e.f_ifid = 1; e.f_idex = 1; e.f_exmem = 1;
          m_flush = sat(m_flush);
        end
      end else begin
        e.hold = 1; e.pc = 0; e.ifid = 0;
        m_stall = sat(m_stall);
        if (m_wait == WM) begin
          m_dead = 1; m_err = 1;
        end else begin
          m_wait++;
        end
      end
    end else if (mw) begin
      e.hold = 1; e.pc = 0; e.ifid = 0;
      m_stall = sat(m_stall);
      m_waiting = 1; m_wait = 1; m_just_stalled = 0;
    end else if (s.br) begin
      e.f_ifid = 1; e.f_idex = 1; e.f_exmem = 1;
      m_flush = sat(m_flush);
      m_just_stalled = 0;
    end else if (lu && !m_just_stalled) begin
      e.pc = 0; e.ifid = 0; e.bub = 1;
      m_stall = sat(m_stall);
      m_just_stalled = 1;
    end else begin
      m_just_stalled = 0;
    end
    return e;
  endfunction

  task automatic apply(input stim_t s, input string name);
    @(posedge clk);
    #1;
    rst_n                = s.rst_n;
    bus.id_valid         = s.valid;
    bus.id_rs            = s.rs;
    bus.id_rt            = s.rt;
    bus.ex_memread       = s.memread;
    bus.ex_rt            = s.exrt;
    bus.mem_branch_taken = s.br;
    bus.dmem_req         = s.req;
    bus.dmem_ready       = s.ready;
    exp_q.push_back(model(s));
    name_q.push_back(name);
  endtask

  function automatic obs_t sample();
    obs_t a;
    a.state   = bus.state;
    a.err     = bus.err;
    a.pc      = bus.pc_write;
    a.ifid    = bus.if_id_write;
    a.bub     = bus.id_ex_bubble;
    a.f_ifid  = bus.if_id_flush;
    a.f_idex  = bus.id_ex_flush;
    a.f_exmem = bus.ex_mem_flush;
    a.hold    = bus.pipe_hold;
    a.stall   = bus.stall_count;
    a.flush   = bus.flush_count;
    return a;
  endfunction

  // Monitor: outputs are presented every cycle; check mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        obs_t  e, a;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = sample();
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s @%0t: got st=%0d err=%0b pc=%0b ifid=%0b bub=%0b fl=%0b%0b%0b hold=%0b stall=%0d flush=%0d, expected st=%0d err=%0b pc=%0b ifid=%0b bub=%0b fl=%0b%0b%0b hold=%0b stall=%0d flush=%0d",
                   nm, $time, a.state, a.err, a.pc, a.ifid, a.bub, a.f_ifid, a.f_idex, a.f_exmem,
                   a.hold, a.stall, a.flush, e.state, e.err, e.pc, e.ifid, e.bub, e.f_ifid,
                   e.f_idex, e.f_exmem, e.hold, e.stall, e.flush);
        end
      end
    end
  end

  initial begin
    stim_t idle, s;
    idle       = '0;
    idle.rst_n = 1'b1;
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.ex_memread = 0; bus.ex_rt = 0;
    bus.mem_branch_taken = 0; bus.dmem_req = 0; bus.dmem_ready = 0;

    s = idle; s.rst_n = 0;
    repeat (2) apply(s, "reset");
    repeat (2) apply(idle, "run_idle");

    // Load-use: lw r5 in EX, decode reads r5.
    s = idle; s.valid = 1; s.rs = 5; s.rt = 7; s.memread = 1; s.exrt = 5;
    apply(s, "lu_stall");
    apply(s, "lu_one_cycle");
    apply(idle, "lu_done");

    // r0 never creates a hazard.
    s = idle; s.valid = 1; s.rs = 3; s.rt = 0; s.memread = 1; s.exrt = 0;
    apply(s, "rt_zero");

    // Branch with a simultaneous load-use hazard.
    s = idle; s.valid = 1; s.rs = 6; s.memread = 1; s.exrt = 6; s.br = 1;
    apply(s, "branch_flush");
    apply(idle, "branch_done");

    // Memory wait of three cycles.
    s = idle; s.req = 1;
    repeat (3) apply(s, "mem_wait");
    s.ready = 1;
    apply(s, "mem_release");
    apply(idle, "mem_done");

    // Branch coinciding with a memory wait is deferred to the release cycle.
    s = idle; s.req = 1; s.br = 1;
    apply(s, "wait_with_branch");
    s.ready = 1;
    apply(s, "release_branch");
    apply(idle, "after_release");

    // Timeout into the error state, then recovery by reset.
    s = idle; s.req = 1;
    repeat (16) apply(s, "mem_timeout");
    s.ready = 1;
    repeat (3) apply(s, "error_sticky");
    s = idle; s.rst_n = 0; s.br = 1; s.req = 1;
    apply(s, "reset_from_error");
    repeat (2) apply(idle, "post_reset");

    // Drive the stall counter past its all-ones limit.
    s = idle; s.valid = 1; s.rs = 9; s.memread = 1; s.exrt = 9;
    repeat (40) apply(s, "stall_saturate");
    apply(idle, "sat_idle");

    for (int i = 0; i < 3000; i++) begin
      s         = idle;
      s.rst_n   = ($urandom_range(0, 59) != 0);
      s.valid   = ($urandom_range(0, 3) != 0);
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.memread = 1'($urandom_range(0, 1));
      s.exrt    = 5'($urandom_range(0, 3));
      s.br      = ($urandom_range(0, 7) == 0);
      s.req     = ($urandom_range(0, 3) == 0);
      s.ready   = ($urandom_range(0, 2) != 0);
      apply(s, "random");
    end

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
